// File: rtl/axi_to_reg_bridge_if.sv
// AXI4 bus bundle between an AXI master and axi_to_reg_bridge.
// Channels: AW, W, B, AR, R. User sideband exists only on B and R.
//   slave  : the bridge view (AXI requests in, responses out)
//   master : the initiator view
interface axi_to_reg_bridge_if #(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 6,
   parameter int unsigned UserWidth = 1
);
   logic                   aw_valid;
   logic                   aw_ready;
   logic [IdWidth-1:0]     aw_id;
   logic [AddrWidth-1:0]   aw_addr;
   logic [7:0]             aw_len;
   logic [2:0]             aw_size;
   logic [1:0]             aw_burst;

   logic                   w_valid;
   logic                   w_ready;
   logic [DataWidth-1:0]   w_data;
   logic [DataWidth/8-1:0] w_strb;
   logic                   w_last;

   logic                   b_valid;
   logic                   b_ready;
   logic [IdWidth-1:0]     b_id;
   logic [1:0]             b_resp;
   logic [UserWidth-1:0]   b_user;

   logic                   ar_valid;
   logic                   ar_ready;
   logic [IdWidth-1:0]     ar_id;
   logic [AddrWidth-1:0]   ar_addr;
   logic [7:0]             ar_len;
   logic [2:0]             ar_size;
   logic [1:0]             ar_burst;

   logic                   r_valid;
   logic                   r_ready;
   logic [IdWidth-1:0]     r_id;
   logic [DataWidth-1:0]   r_data;
   logic [1:0]             r_resp;
   logic                   r_last;
   logic [UserWidth-1:0]   r_user;

   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_id, b_resp, b_user,
      input  b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      output ar_ready,
      output r_valid, r_id, r_data, r_resp, r_last, r_user,
      input  r_ready
   );

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_id, b_resp, b_user,
      output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      input  ar_ready,
      input  r_valid, r_id, r_data, r_resp, r_last, r_user,
      output r_ready
   );
endinterface

// File: rtl/axi_to_reg_bridge.sv
// AXI4 slave to single-word valid/ready register bus bridge.
// Every AXI channel passes through a 2-entry spill register, so all AXI
// valid/ready/data outputs come straight from flops. One burst is in service
// at a time; each beat becomes one register access.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   axi                AXI4 slave port (axi_to_reg_bridge_if.slave)
//   reg_valid_o/ready_i   register request handshake
//   reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o   request fields
//   reg_rdata_i, reg_error_i   response, sampled with reg_ready_i

// 2-entry spill register: ready and valid are both flop outputs while
// still sustaining one transfer per cycle.
module axi_to_reg_bridge_spill #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o
);
   logic             a_full_q, b_full_q;
   logic [Width-1:0] a_q, b_q;
   logic             push, pop;

   assign push = in_valid_i && !b_full_q;
   assign pop  = a_full_q && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else if (pop) begin
         // push never coincides with b full, so the skid slot only drains here
         if (b_full_q) begin
            a_q      <= b_q;
            b_full_q <= 1'b0;
         end else if (push) begin
            a_q <= in_data_i;
         end else begin
            a_full_q <= 1'b0;
         end
      end else if (push) begin
         if (!a_full_q) begin
            a_q      <= in_data_i;
            a_full_q <= 1'b1;
         end else begin
            b_q      <= in_data_i;
            b_full_q <= 1'b1;
         end
      end
   end

   assign in_ready_o  = !b_full_q;
   assign out_valid_o = a_full_q;
   assign out_data_o  = a_q;
endmodule

// state   | meaning
// IDLE    | no burst in service, arbitrating AW vs AR
// WR_BEAT | issuing register writes, one per W beat
// WR_RESP | presenting the single B response
// RD_BEAT | issuing a register read for the current beat
// RD_DATA | presenting the captured read data as an R beat
module axi_to_reg_bridge #(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 6,
   parameter int unsigned UserWidth = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   axi_to_reg_bridge_if.slave     axi,
   output logic                   reg_valid_o,
   input  logic                   reg_ready_i,
   output logic                   reg_write_o,
   output logic [AddrWidth-1:0]   reg_addr_o,
   output logic [DataWidth-1:0]   reg_wdata_o,
   output logic [DataWidth/8-1:0] reg_wstrb_o,
   input  logic [DataWidth-1:0]   reg_rdata_i,
   input  logic                   reg_error_i
);
   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned SizeMax   = $clog2(StrbWidth);
   localparam int unsigned AxWidth   = IdWidth + AddrWidth + 8 + 3 + 2;
   localparam int unsigned WWidth    = DataWidth + StrbWidth + 1;
   localparam int unsigned BWidth    = IdWidth + 2;
   localparam int unsigned RWidth    = IdWidth + DataWidth + 2 + 1;

   typedef enum logic [2:0] {IDLE, WR_BEAT, WR_RESP, RD_BEAT, RD_DATA} state_e;
   state_e state_q, state_d;

   logic                 aw_q_valid, aw_q_ready, ar_q_valid, ar_q_ready;
   logic                 w_q_valid, w_q_ready;
   logic                 b_in_valid, b_in_ready, r_in_valid, r_in_ready;
   logic [AxWidth-1:0]   aw_q_data, ar_q_data;
   logic [WWidth-1:0]    w_q_data;
   logic [BWidth-1:0]    b_in_data, b_out_data;
   logic [RWidth-1:0]    r_in_data, r_out_data;

   logic [IdWidth-1:0]   aw_q_id, ar_q_id;
   logic [AddrWidth-1:0] aw_q_addr, ar_q_addr;
   logic [7:0]           aw_q_len, ar_q_len;
   logic [2:0]           aw_q_size, ar_q_size;
   logic [1:0]           aw_q_burst, ar_q_burst;
   logic [DataWidth-1:0] w_q_wdata;
   logic [StrbWidth-1:0] w_q_strb;
   logic                 unused_w_last;

   logic [IdWidth-1:0]   id_q;
   logic [AddrWidth-1:0] addr_q, addr_next, beat_bytes;
   logic [7:0]           len_q, beat_cnt_q;
   logic [2:0]           size_q, eff_size;
   logic [1:0]           burst_q;
   logic                 wr_err_q, rd_err_q, prefer_wr_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 wr_win, rd_win, last_beat;

   axi_to_reg_bridge_spill #(.Width(AxWidth)) i_aw_spill (
      .clk_i, .rst_ni,
      .in_valid_i  (axi.aw_valid),
      .in_ready_o  (axi.aw_ready),
      .in_data_i   ({axi.aw_id, axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst}),
      .out_valid_o (aw_q_valid),
      .out_ready_i (aw_q_ready),
      .out_data_o  (aw_q_data)
   );

   axi_to_reg_bridge_spill #(.Width(WWidth)) i_w_spill (
      .clk_i, .rst_ni,
      .in_valid_i  (axi.w_valid),
      .in_ready_o  (axi.w_ready),
      .in_data_i   ({axi.w_data, axi.w_strb, axi.w_last}),
      .out_valid_o (w_q_valid),
      .out_ready_i (w_q_ready),
      .out_data_o  (w_q_data)
   );

   axi_to_reg_bridge_spill #(.Width(AxWidth)) i_ar_spill (
      .clk_i, .rst_ni,
      .in_valid_i  (axi.ar_valid),
      .in_ready_o  (axi.ar_ready),
      .in_data_i   ({axi.ar_id, axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst}),
      .out_valid_o (ar_q_valid),
      .out_ready_i (ar_q_ready),
      .out_data_o  (ar_q_data)
   );

   axi_to_reg_bridge_spill #(.Width(BWidth)) i_b_spill (
      .clk_i, .rst_ni,
      .in_valid_i  (b_in_valid),
      .in_ready_o  (b_in_ready),
      .in_data_i   (b_in_data),
      .out_valid_o (axi.b_valid),
      .out_ready_i (axi.b_ready),
      .out_data_o  (b_out_data)
   );

   axi_to_reg_bridge_spill #(.Width(RWidth)) i_r_spill (
      .clk_i, .rst_ni,
      .in_valid_i  (r_in_valid),
      .in_ready_o  (r_in_ready),
      .in_data_i   (r_in_data),
      .out_valid_o (axi.r_valid),
      .out_ready_i (axi.r_ready),
      .out_data_o  (r_out_data)
   );

   assign {aw_q_id, aw_q_addr, aw_q_len, aw_q_size, aw_q_burst} = aw_q_data;
   assign {ar_q_id, ar_q_addr, ar_q_len, ar_q_size, ar_q_burst} = ar_q_data;
   // beat count comes from the AW length, so w_last carries no information
   assign {w_q_wdata, w_q_strb, unused_w_last} = w_q_data;

   assign {axi.b_id, axi.b_resp} = b_out_data;
   assign {axi.r_id, axi.r_data, axi.r_resp, axi.r_last} = r_out_data;
   assign axi.b_user = {UserWidth{1'b0}};
   assign axi.r_user = {UserWidth{1'b0}};

   // Ties alternate; prefer_wr_q starts at 0 so the first tie goes to the read.
   assign wr_win = aw_q_valid && (!ar_q_valid || prefer_wr_q);
   assign rd_win = ar_q_valid && !wr_win;

   assign last_beat = (beat_cnt_q == len_q);

   // Oversized beats are clamped to the bus width; WRAP advances like INCR.
   assign eff_size   = (size_q > 3'(SizeMax)) ? 3'(SizeMax) : size_q;
   assign beat_bytes = AddrWidth'(1) << eff_size;
   assign addr_next  = (burst_q == 2'b00) ? addr_q
                     : ((addr_q & ~(beat_bytes - AddrWidth'(1))) + beat_bytes);

   assign b_in_data = {id_q, wr_err_q ? 2'b10 : 2'b00};
   assign r_in_data = {id_q, rdata_q, rd_err_q ? 2'b10 : 2'b00, last_beat};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_win)      state_d = WR_BEAT;
            else if (rd_win) state_d = RD_BEAT;
         end
         WR_BEAT: if (w_q_valid && reg_ready_i && last_beat) state_d = WR_RESP;
         WR_RESP: if (b_in_ready) state_d = IDLE;
         RD_BEAT: if (reg_ready_i) state_d = RD_DATA;
         RD_DATA: if (r_in_ready) state_d = last_beat ? IDLE : RD_BEAT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      aw_q_ready  = 1'b0;
      ar_q_ready  = 1'b0;
      w_q_ready   = 1'b0;
      b_in_valid  = 1'b0;
      r_in_valid  = 1'b0;
      reg_valid_o = 1'b0;
      reg_write_o = 1'b0;
      case (state_q)
         IDLE: begin
            aw_q_ready = wr_win;
            ar_q_ready = rd_win;
         end
         WR_BEAT: begin
            // W spill output holds until popped, so the request cannot change
            reg_valid_o = w_q_valid;
            reg_write_o = 1'b1;
            w_q_ready   = reg_ready_i;
         end
         WR_RESP: b_in_valid  = 1'b1;
         RD_BEAT: reg_valid_o = 1'b1;
         RD_DATA: r_in_valid  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         beat_cnt_q  <= '0;
         wr_err_q    <= 1'b0;
         rd_err_q    <= 1'b0;
         rdata_q     <= '0;
         prefer_wr_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (aw_q_valid && ar_q_valid) prefer_wr_q <= ~prefer_wr_q;
               if (wr_win) begin
                  id_q    <= aw_q_id;
                  addr_q  <= aw_q_addr;
                  len_q   <= aw_q_len;
                  size_q  <= aw_q_size;
                  burst_q <= aw_q_burst;
               end else if (rd_win) begin
                  id_q    <= ar_q_id;
                  addr_q  <= ar_q_addr;
                  len_q   <= ar_q_len;
                  size_q  <= ar_q_size;
                  burst_q <= ar_q_burst;
               end
               beat_cnt_q <= '0;
               wr_err_q   <= 1'b0;
            end
            WR_BEAT: begin
               if (w_q_valid && reg_ready_i) begin
                  addr_q     <= addr_next;
                  beat_cnt_q <= beat_cnt_q + 8'd1;
                  wr_err_q   <= wr_err_q | reg_error_i;
               end
            end
            RD_BEAT: begin
               if (reg_ready_i) begin
                  rdata_q  <= reg_rdata_i;
                  rd_err_q <= reg_error_i;
                  addr_q   <= addr_next;
               end
            end
            RD_DATA: begin
               if (r_in_ready) beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = w_q_wdata;
   assign reg_wstrb_o = w_q_strb;
endmodule

// File: tb/tb_axi_to_reg_bridge.sv
// Directed bench for axi_to_reg_bridge: AXI master driven from one initial
// block, register slave modelled by a few continuous assigns, handshakes
// logged at the falling edge and checked against hand-computed values.
module tb_axi_to_reg_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_to_reg_bridge_if #(.AddrWidth(48), .DataWidth(64), .IdWidth(6), .UserWidth(1)) bus ();

   logic        reg_valid, reg_ready, reg_write, reg_error;
   logic [47:0] reg_addr;
   logic [63:0] reg_wdata, reg_rdata, rdata_fixed;
   logic [7:0]  reg_wstrb;
   logic        rdata_fixed_en, err_wr_en, err_rd_en;
   logic        r_ready_lvl, b_ready_lvl, tog_en, tog_phase;

   axi_to_reg_bridge #(.AddrWidth(48), .DataWidth(64), .IdWidth(6), .UserWidth(1)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .axi         (bus),
      .reg_valid_o (reg_valid),
      .reg_ready_i (reg_ready),
      .reg_write_o (reg_write),
      .reg_addr_o  (reg_addr),
      .reg_wdata_o (reg_wdata),
      .reg_wstrb_o (reg_wstrb),
      .reg_rdata_i (reg_rdata),
      .reg_error_i (reg_error)
   );

   assign reg_rdata   = rdata_fixed_en ? rdata_fixed : {16'hBEEF, reg_addr};
   assign reg_error   = (err_wr_en && reg_write) || (err_rd_en && !reg_write);
   assign bus.r_ready = tog_en ? tog_phase  : r_ready_lvl;
   assign bus.b_ready = tog_en ? ~tog_phase : b_ready_lvl;

   initial begin
      tog_phase = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tog_phase = ~tog_phase;
      end
   end

   typedef struct {logic wr; logic [47:0] addr; logic [63:0] data; logic [7:0] strb;} reg_t;
   typedef struct {logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_t;
   typedef struct {logic [5:0] id; logic [1:0] resp;} b_t;
   reg_t reg_log[$];
   r_t   r_log[$];
   b_t   b_log[$];

   always @(negedge clk) begin
      if (rst_n && reg_valid && reg_ready)
         reg_log.push_back('{wr: reg_write, addr: reg_addr, data: reg_wdata, strb: reg_wstrb});
      if (rst_n && bus.r_valid && bus.r_ready)
         r_log.push_back('{id: bus.r_id, data: bus.r_data, resp: bus.r_resp, last: bus.r_last});
      if (rst_n && bus.b_valid && bus.b_ready)
         b_log.push_back('{id: bus.b_id, resp: bus.b_resp});
   end

   int checks = 0;
   int errors = 0;
   int rb, rr, bb;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int count(input int sel);
      case (sel)
         0:       return reg_log.size();
         1:       return r_log.size();
         default: return b_log.size();
      endcase
   endfunction

   // waits for a log to reach n entries, lets the design idle, then demands exactly n
   task automatic wait_for(input int sel, input int n, input string tag);
      int t = 0;
      while (count(sel) < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (8) @(negedge clk);
      check(tag, 64'(count(sel)), 64'(n));
   endtask

   task automatic send_aw(input logic [5:0] id, input logic [47:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t = 0;
      bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
      bus.aw_size = size; bus.aw_burst = burst; bus.aw_valid = 1'b1;
      @(negedge clk);
      while (!bus.aw_ready && t < 200) begin @(negedge clk); t++; end
      check("aw_accept", 64'(bus.aw_ready), 64'd1);
      step();
      bus.aw_valid = 1'b0;
   endtask

   task automatic send_ar(input logic [5:0] id, input logic [47:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t = 0;
      bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
      bus.ar_size = size; bus.ar_burst = burst; bus.ar_valid = 1'b1;
      @(negedge clk);
      while (!bus.ar_ready && t < 200) begin @(negedge clk); t++; end
      check("ar_accept", 64'(bus.ar_ready), 64'd1);
      step();
      bus.ar_valid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d0, input logic [7:0] strb, input int n);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         bus.w_data = d0 + 64'(i); bus.w_strb = strb;
         bus.w_last = (i == n - 1); bus.w_valid = 1'b1;
         @(negedge clk);
         while (!bus.w_ready && t < 200) begin @(negedge clk); t++; end
         check("w_accept", 64'(bus.w_ready), 64'd1);
         step();
      end
      bus.w_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
      bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
      bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
      reg_ready = 1; rdata_fixed_en = 0; rdata_fixed = '0; err_wr_en = 0; err_rd_en = 0;
      r_ready_lvl = 1; b_ready_lvl = 1; tog_en = 0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_b_valid", 64'(bus.b_valid), 64'd0);
      check("rst_r_valid", 64'(bus.r_valid), 64'd0);
      check("rst_reg_valid", 64'(reg_valid), 64'd0);
      check("rst_r_data", bus.r_data, 64'd0);
      check("rst_reg_addr", 64'(reg_addr), 64'd0);
      rst_n = 1;
      step();

      // single write
      rb = reg_log.size(); bb = b_log.size();
      fork
         send_aw(6'd5, 48'h1000, 8'd0, 3'd3, 2'd1);
         send_w(64'h1122334455667788, 8'hFF, 1);
      join
      wait_for(0, rb + 1, "wr1_reg_count");
      wait_for(2, bb + 1, "wr1_b_count");
      check("wr1_reg_wr", 64'(reg_log[rb].wr), 64'd1);
      check("wr1_reg_addr", 64'(reg_log[rb].addr), 64'h1000);
      check("wr1_reg_data", reg_log[rb].data, 64'h1122334455667788);
      check("wr1_reg_strb", 64'(reg_log[rb].strb), 64'hFF);
      check("wr1_b_id", 64'(b_log[bb].id), 64'd5);
      check("wr1_b_resp", 64'(b_log[bb].resp), 64'd0);

      // single read
      step();
      rb = reg_log.size(); rr = r_log.size();
      rdata_fixed_en = 1; rdata_fixed = 64'hDEADBEEFCAFEF00D;
      send_ar(6'd3, 48'h2008, 8'd0, 3'd3, 2'd1);
      wait_for(1, rr + 1, "rd1_r_count");
      check("rd1_reg_count", 64'(reg_log.size()), 64'(rb + 1));
      check("rd1_reg_wr", 64'(reg_log[rb].wr), 64'd0);
      check("rd1_reg_addr", 64'(reg_log[rb].addr), 64'h2008);
      check("rd1_r_data", r_log[rr].data, 64'hDEADBEEFCAFEF00D);
      check("rd1_r_id", 64'(r_log[rr].id), 64'd3);
      check("rd1_r_last", 64'(r_log[rr].last), 64'd1);
      check("rd1_r_resp", 64'(r_log[rr].resp), 64'd0);
      rdata_fixed_en = 0;

      // INCR read burst of 4
      step();
      rb = reg_log.size(); rr = r_log.size();
      send_ar(6'd4, 48'h3000, 8'd3, 3'd3, 2'd1);
      wait_for(1, rr + 4, "burst_r_count");
      for (int i = 0; i < 4; i++) begin
         check("burst_reg_addr", 64'(reg_log[rb + i].addr), 64'h3000 + 64'(8 * i));
         check("burst_r_data", r_log[rr + i].data, 64'hBEEF000000003000 + 64'(8 * i));
         check("burst_r_last", 64'(r_log[rr + i].last), 64'(i == 3));
      end

      // register backpressure: request must hold steady while reg_ready is low
      step();
      reg_ready = 0;
      rb = reg_log.size(); rr = r_log.size();
      send_ar(6'd6, 48'h9000, 8'd1, 3'd3, 2'd1);
      begin
         int t = 0;
         while (!reg_valid && t < 100) begin @(negedge clk); t++; end
      end
      check("bp_req_seen", 64'(reg_valid), 64'd1);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid_hold", 64'(reg_valid), 64'd1);
         check("bp_addr_hold", 64'(reg_addr), 64'h9000);
         check("bp_write_hold", 64'(reg_write), 64'd0);
      end
      step();
      reg_ready = 1;
      tog_en = 1;
      wait_for(1, rr + 2, "bp_r_count");
      check("bp_reg_count", 64'(reg_log.size()), 64'(rb + 2));
      check("bp_r0_data", r_log[rr].data, 64'hBEEF000000009000);
      check("bp_r0_last", 64'(r_log[rr].last), 64'd0);
      check("bp_r1_data", r_log[rr + 1].data, 64'hBEEF000000009008);
      check("bp_r1_last", 64'(r_log[rr + 1].last), 64'd1);

      // write burst with toggling b_ready
      step();
      rb = reg_log.size(); bb = b_log.size();
      fork
         send_aw(6'd7, 48'hA000, 8'd1, 3'd3, 2'd1);
         send_w(64'h100, 8'h0F, 2);
      join
      wait_for(2, bb + 1, "bpw_b_count");
      tog_en = 0;
      check("bpw_reg_count", 64'(reg_log.size()), 64'(rb + 2));
      check("bpw_addr0", 64'(reg_log[rb].addr), 64'hA000);
      check("bpw_data0", reg_log[rb].data, 64'h100);
      check("bpw_strb0", 64'(reg_log[rb].strb), 64'h0F);
      check("bpw_addr1", 64'(reg_log[rb + 1].addr), 64'hA008);
      check("bpw_data1", reg_log[rb + 1].data, 64'h101);
      check("bpw_b_id", 64'(b_log[bb].id), 64'd7);

      // first AW/AR tie: read first; write error gives SLVERR
      step();
      rb = reg_log.size(); rr = r_log.size(); bb = b_log.size();
      err_wr_en = 1;
      fork
         send_aw(6'd1, 48'h7000, 8'd0, 3'd3, 2'd1);
         send_w(64'h5555, 8'hFF, 1);
         send_ar(6'd2, 48'h7100, 8'd0, 3'd3, 2'd1);
      join
      wait_for(2, bb + 1, "tie1_b_count");
      err_wr_en = 0;
      check("tie1_r_count", 64'(r_log.size()), 64'(rr + 1));
      check("tie1_first_wr", 64'(reg_log[rb].wr), 64'd0);
      check("tie1_first_addr", 64'(reg_log[rb].addr), 64'h7100);
      check("tie1_second_wr", 64'(reg_log[rb + 1].wr), 64'd1);
      check("tie1_second_addr", 64'(reg_log[rb + 1].addr), 64'h7000);
      check("tie1_b_resp", 64'(b_log[bb].resp), 64'd2);
      check("tie1_b_id", 64'(b_log[bb].id), 64'd1);
      check("tie1_r_id", 64'(r_log[rr].id), 64'd2);
      check("tie1_r_resp", 64'(r_log[rr].resp), 64'd0);

      // second tie: write wins
      step();
      rb = reg_log.size(); rr = r_log.size(); bb = b_log.size();
      fork
         send_aw(6'd8, 48'h7200, 8'd0, 3'd3, 2'd1);
         send_w(64'h6666, 8'hFF, 1);
         send_ar(6'd9, 48'h7300, 8'd0, 3'd3, 2'd1);
      join
      wait_for(1, rr + 1, "tie2_r_count");
      check("tie2_first_wr", 64'(reg_log[rb].wr), 64'd1);
      check("tie2_first_addr", 64'(reg_log[rb].addr), 64'h7200);
      check("tie2_second_addr", 64'(reg_log[rb + 1].addr), 64'h7300);
      check("tie2_b_resp", 64'(b_log[bb].resp), 64'd0);

      // read error on every beat
      step();
      rr = r_log.size();
      err_rd_en = 1;
      send_ar(6'd10, 48'hB000, 8'd1, 3'd3, 2'd1);
      wait_for(1, rr + 2, "rerr_r_count");
      err_rd_en = 0;
      check("rerr_resp0", 64'(r_log[rr].resp), 64'd2);
      check("rerr_data0", r_log[rr].data, 64'hBEEF00000000B000);
      check("rerr_resp1", 64'(r_log[rr + 1].resp), 64'd2);

      // addressing corners: unaligned INCR, oversized size, address wrap
      step();
      rb = reg_log.size(); rr = r_log.size();
      send_ar(6'd11, 48'h4003, 8'd1, 3'd2, 2'd1);
      wait_for(1, rr + 2, "unal_r_count");
      check("unal_addr0", 64'(reg_log[rb].addr), 64'h4003);
      check("unal_addr1", 64'(reg_log[rb + 1].addr), 64'h4004);
      step();
      rb = reg_log.size(); rr = r_log.size();
      send_ar(6'd12, 48'h5001, 8'd1, 3'd7, 2'd1);
      wait_for(1, rr + 2, "big_r_count");
      check("big_addr1", 64'(reg_log[rb + 1].addr), 64'h5008);
      step();
      rb = reg_log.size(); rr = r_log.size();
      send_ar(6'd13, 48'hFFFF_FFFF_FFF8, 8'd1, 3'd3, 2'd2);
      wait_for(1, rr + 2, "wrap_r_count");
      check("wrap_addr1", 64'(reg_log[rb + 1].addr), 64'h0);
      check("wrap_data1", r_log[rr + 1].data, 64'hBEEF000000000000);

      // FIXED write burst stays on one address
      step();
      rb = reg_log.size(); bb = b_log.size();
      fork
         send_aw(6'd14, 48'h6000, 8'd1, 3'd3, 2'd0);
         send_w(64'h10, 8'hFF, 2);
      join
      wait_for(2, bb + 1, "fixed_b_count");
      check("fixed_addr0", 64'(reg_log[rb].addr), 64'h6000);
      check("fixed_addr1", 64'(reg_log[rb + 1].addr), 64'h6000);
      check("fixed_data1", reg_log[rb + 1].data, 64'h11);

      // reset in the middle of a len=7 read
      step();
      rb = reg_log.size();
      send_ar(6'd15, 48'hC000, 8'd7, 3'd3, 2'd1);
      begin
         int t = 0;
         while (reg_log.size() < rb + 2 && t < 200) begin @(negedge clk); t++; end
      end
      check("mid_beats_seen", 64'(reg_log.size() >= rb + 2), 64'd1);
      step();
      rst_n = 0;
      #1;
      check("mid_rst_r_valid", 64'(bus.r_valid), 64'd0);
      check("mid_rst_b_valid", 64'(bus.b_valid), 64'd0);
      check("mid_rst_reg_valid", 64'(reg_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      repeat (5) @(negedge clk);
      rb = reg_log.size(); rr = r_log.size();
      check("post_rst_idle", 64'(reg_valid), 64'd0);
      step();
      send_ar(6'd16, 48'hD000, 8'd0, 3'd3, 2'd1);
      wait_for(1, rr + 1, "post_rst_r_count");
      check("post_rst_reg_count", 64'(reg_log.size()), 64'(rb + 1));
      check("post_rst_addr", 64'(reg_log[rb].addr), 64'hD000);
      check("post_rst_r_data", r_log[rr].data, 64'hBEEF00000000D000);
      check("post_rst_r_id", 64'(r_log[rr].id), 64'd16);
      check("post_rst_r_last", 64'(r_log[rr].last), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
